// File: rtl/onehot_sel_decoder.sv
// Registered binary-to-one-hot select decoder with a valid/ready input handshake.
// Defining ONEHOT_SEL_DECODER_SCAN_EN adds a scan mode that sweeps every select in turn.
module onehot_sel_decoder #(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  output logic                sel_ready,
  output logic [2**SEL_W-1:0] onehot,
  output logic                onehot_valid,
  output logic [SEL_W-1:0]    index,
  output logic                wrap
);

  localparam int ONE_W = 2**SEL_W;

  logic [ONE_W-1:0] onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic             accept;
  logic [ONE_W-1:0] dec_onehot;

  assign dec_onehot   = ONE_W'(1) << sel;
  assign accept       = sel_valid & sel_ready;
  assign onehot       = onehot_q;
  assign onehot_valid = valid_q;
  assign index        = index_q;

`ifdef ONEHOT_SEL_DECODER_SCAN_EN

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap_q, wrap_d;

  assign sel_ready = en & ~mode;
  assign wrap      = wrap_q;

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    index_d  = index_q;
    div_d    = div_q;
    wrap_d   = 1'b0;
    if (en) begin
      case (state_q)
        IDLE, DIRECT: begin
          if (mode) begin
            state_d  = SCAN;
            onehot_d = ONE_W'(1);
            index_d  = '0;
            valid_d  = 1'b1;
            div_d    = '0;
          end else if (accept) begin
            state_d  = DIRECT;
            onehot_d = dec_onehot;
            index_d  = sel;
            valid_d  = 1'b1;
          end
        end
        SCAN: begin
          if (mode) begin
            if (div_q == DIV_LAST) begin
              div_d    = '0;
              index_d  = index_q + 1'b1;
              onehot_d = {onehot_q[ONE_W-2:0], onehot_q[ONE_W-1]};
              wrap_d   = (index_q == {SEL_W{1'b1}});
            end else begin
              div_d = div_q + 1'b1;
            end
          end else begin
            // Leaving scan: a same-cycle request wins over dropping to IDLE.
            div_d = '0;
            if (accept) begin
              state_d  = DIRECT;
              onehot_d = dec_onehot;
              index_d  = sel;
              valid_d  = 1'b1;
            end else begin
              state_d  = IDLE;
              onehot_d = '0;
              valid_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wrap_q  <= wrap_d;
    end
  end

`else

  typedef enum logic {IDLE, DIRECT} state_t;

  state_t state_q, state_d;
  logic   unused_mode;

  assign unused_mode = mode;
  assign sel_ready   = en;
  assign wrap        = 1'b0;

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    index_d  = index_q;
    if (accept) begin
      state_d  = DIRECT;
      onehot_d = dec_onehot;
      index_d  = sel;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      onehot_q <= '0;
      valid_q  <= 1'b0;
      index_q  <= '0;
    end else begin
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      index_q  <= index_d;
    end
  end

endmodule
